// File: rtl/bp_stream_pump_out_arb.sv
// Arbitrates several FSM-style requesters onto one stream pump, holding the grant for multi-beat messages.
// Define BP_STREAM_PUMP_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index first).
module bp_stream_pump_out_arb #(
  parameter int num_clients_p  = 2,
  // Stands in for bp_bedrock_xce_mem_msg_header_width_lp when built outside the BlackParrot packages.
  parameter int header_width_p = 64,
  parameter int data_width_p   = 64
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_clients_p*header_width_p-1:0] client_header_i,
  input  logic [num_clients_p*data_width_p-1:0]   client_data_i,
  input  logic [num_clients_p-1:0]                client_v_i,
  output logic [num_clients_p-1:0]                client_yumi_o,
  output logic [header_width_p-1:0]               pump_header_o,
  output logic [data_width_p-1:0]                 pump_data_o,
  output logic                                    pump_v_o,
  input  logic                                    pump_yumi_i,
  input  logic                                    pump_done_i,
  output logic [num_clients_p-1:0]                grant_o,
  output logic                                    busy_o
);

  typedef enum logic [0:0] {
    e_idle   = 1'b0,
    e_locked = 1'b1
  } state_e;

  state_e                   state_r;
  state_e                   state_n_s;
  logic [num_clients_p-1:0] lock_grant_r;
  logic [num_clients_p-1:0] lock_grant_n_s;
  logic [num_clients_p-1:0] win_s;
  logic [num_clients_p-1:0] grant_s;
  logic [header_width_p-1:0] header_s;
  logic [data_width_p-1:0]   data_s;

`ifdef BP_STREAM_PUMP_ARB_RR_EN
  localparam int ptr_w_lp = (num_clients_p > 1) ? $clog2(num_clients_p) : 1;

  logic [ptr_w_lp-1:0] ptr_r;
  logic [ptr_w_lp-1:0] ptr_n_s;

  // Index of the set bit of a one-hot grant.
  function automatic logic [ptr_w_lp-1:0] onehot_to_idx(input logic [num_clients_p-1:0] oh);
    logic [ptr_w_lp-1:0] idx;
    idx = '0;
    for (int i = 0; i < num_clients_p; i++) begin
      if (oh[i]) begin
        idx = ptr_w_lp'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Priority start for the next message: the client just after the one that completed.
  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] idx);
    logic [ptr_w_lp-1:0] nxt;
    if (int'(idx) >= num_clients_p - 1) begin
      nxt = '0;
    end else begin
      nxt = idx + ptr_w_lp'(1);
    end
    return nxt;
  endfunction

  // Round-robin winner: first valid client at or after the pointer, wrapping.
  always_comb begin
    int  idx;
    logic found;
    win_s = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < num_clients_p; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= num_clients_p) begin
        idx = idx - num_clients_p;
      end else begin
        idx = idx;
      end
      if (!found && client_v_i[idx]) begin
        win_s[idx] = 1'b1;
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end
`else
  // Fixed-priority winner: lowest valid index.
  always_comb begin
    logic found;
    win_s = '0;
    found = 1'b0;
    for (int i = 0; i < num_clients_p; i++) begin
      if (!found && client_v_i[i]) begin
        win_s[i] = 1'b1;
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
  end
`endif

  // Effective grant; forced to zero while reset is asserted so nothing leaks to the pump.
  always_comb begin
    grant_s = '0;
    if (!reset_n_i) begin
      grant_s = '0;
    end else if (num_clients_p == 1) begin
      grant_s = client_v_i;
    end else if (state_r == e_locked) begin
      grant_s = lock_grant_r;
    end else begin
      grant_s = win_s;
    end
  end

  // AND-OR mux of the granted client's header and data.
  always_comb begin
    header_s = '0;
    data_s   = '0;
    for (int i = 0; i < num_clients_p; i++) begin
      if (grant_s[i]) begin
        header_s = header_s | client_header_i[i*header_width_p +: header_width_p];
        data_s   = data_s   | client_data_i[i*data_width_p +: data_width_p];
      end else begin
        header_s = header_s;
        data_s   = data_s;
      end
    end
  end

  assign grant_o       = grant_s;
  assign pump_header_o = header_s;
  assign pump_data_o   = data_s;
  assign pump_v_o      = |(grant_s & client_v_i);
  assign client_yumi_o = grant_s & {num_clients_p{pump_yumi_i}};
  assign busy_o        = (state_r == e_locked);

  // Next-state: lock on a consumed beat that does not end the message, unlock on done.
  always_comb begin
    state_n_s      = state_r;
    lock_grant_n_s = lock_grant_r;
`ifdef BP_STREAM_PUMP_ARB_RR_EN
    ptr_n_s        = ptr_r;
`endif
    case (state_r)
      e_idle: begin
        if (pump_yumi_i && (|grant_s)) begin
          if (pump_done_i) begin
            state_n_s = e_idle;
`ifdef BP_STREAM_PUMP_ARB_RR_EN
            ptr_n_s   = next_ptr(onehot_to_idx(grant_s));
`endif
          end else begin
            state_n_s      = e_locked;
            lock_grant_n_s = grant_s;
          end
        end else begin
          state_n_s = e_idle;
        end
      end
      e_locked: begin
        if (pump_done_i) begin
          state_n_s      = e_idle;
          lock_grant_n_s = '0;
`ifdef BP_STREAM_PUMP_ARB_RR_EN
          ptr_n_s        = next_ptr(onehot_to_idx(lock_grant_r));
`endif
        end else begin
          state_n_s = e_locked;
        end
      end
      default: begin
        state_n_s      = e_idle;
        lock_grant_n_s = '0;
      end
    endcase
  end

  // State, latched grant and (when enabled) arbitration pointer.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= e_idle;
      lock_grant_r <= '0;
`ifdef BP_STREAM_PUMP_ARB_RR_EN
      ptr_r        <= '0;
`endif
    end else begin
      state_r      <= state_n_s;
      lock_grant_r <= lock_grant_n_s;
`ifdef BP_STREAM_PUMP_ARB_RR_EN
      ptr_r        <= ptr_n_s;
`endif
    end
  end

endmodule

// File: doc/bp_stream_pump_out_arb.md
BP_STREAM_PUMP_OUT_ARB -- requirements
Module: bp_stream_pump_out_arb

Interface
REQ-001 SHALL have parameter num_clients_p, default 2, number of FSM requesters (1..8).
REQ-002 SHALL have parameter header_width_p, default bp_bedrock_xce_mem_msg_header_width_lp, BedRock mem header width.
REQ-003 SHALL have parameter data_width_p, default dword_width_p, stream beat width.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n_i  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port client_header_i  input  num_clients_p*header_width_p  per-client base header, client i at slice i.
REQ-007 SHALL have port client_data_i  input  num_clients_p*data_width_p  per-client beat data.
REQ-008 SHALL have port client_v_i  input  num_clients_p  per-client valid.
REQ-009 SHALL have port client_yumi_o  output  num_clients_p  per-client beat consumed.
REQ-010 SHALL have ports pump_header_o, pump_data_o, pump_v_o  output  header_width_p, data_width_p, 1  to pump fsm_base_header_i, fsm_data_i, fsm_v_i.
REQ-011 SHALL have port pump_yumi_i  input  1  from pump fsm_yumi_o.
REQ-012 SHALL have port pump_done_i  input  1  from pump done_o; message complete.
REQ-013 SHALL have port grant_o  output  num_clients_p  one-hot current grant, zero when none.
REQ-014 SHALL have port busy_o  output  1  high while in e_locked.

Function
REQ-015 SHALL implement two states: e_idle (arbitrating) and e_locked (grant held for a multi-beat message).
REQ-016 In e_idle, SHALL select winner combinationally among asserted client_v_i; grant_o = winner one-hot, zero if no valid.
REQ-017 SHALL forward the granted client's header, data, and valid to pump outputs; pump_v_o = 0 when no grant.
REQ-018 SHALL assert client_yumi_o[i] = pump_yumi_i & grant_o[i]; all other yumi bits 0.
REQ-019 In e_idle, pump_yumi_i & ~pump_done_i SHALL latch the grant and move to e_locked next cycle.
REQ-020 In e_idle, pump_yumi_i & pump_done_i (single-beat message) SHALL remain in e_idle and advance the arbitration pointer.
REQ-021 In e_locked, SHALL grant only the latched client regardless of other valids, including cycles where that client drops valid.
REQ-022 In e_locked, pump_done_i SHALL return to e_idle next cycle and advance the pointer; new arbitration starts that next cycle, never the same cycle.
REQ-023 Pump beats consumed without done (write-response combining) SHALL keep e_locked.
REQ-024 Arbitration pointer SHALL change only on message completion, so the idle grant is stable while requesters hold valid (valid-then-yumi; no valid retraction by clients).
REQ-025 pump_done_i without pump_yumi_i in e_idle SHALL be ignored.
REQ-026 num_clients_p = 1 SHALL degenerate to a pass-through with grant_o = client_v_i and no lock error.

Reset
REQ-027 Asserting reset_n_i low SHALL asynchronously force e_idle, pointer = 0, latched grant = 0, busy_o = 0.
REQ-028 During reset, grant_o, pump_v_o, and client_yumi_o SHALL be 0 regardless of inputs.
REQ-029 Reset mid-message SHALL abandon the message; after release, arbitration restarts from client 0 priority.

Configuration
REQ-030 With BP_STREAM_PUMP_ARB_RR_EN defined, winner SHALL be round-robin: first valid index after the last completed winner, wrapping; the pointer is a clog2(num_clients_p)-bit register.
REQ-031 Without BP_STREAM_PUMP_ARB_RR_EN, winner SHALL be fixed priority with lowest index first; no pointer register exists.

Verification
REQ-032 Two clients, both valid with single-beat headers (size 8B, 64-bit beats), RR on -> grants alternate 0,1,0,1 and each completion is one cycle.
REQ-033 Client 0 sends 64B write (8 beats) while client 1 is valid throughout -> grant_o stays 01 for 8 yumis, busy_o high from cycle 2 through the done cycle, and 10 appears the cycle after done.
REQ-034 Locked client 0 drops valid for 3 cycles mid-stream while client 1 is valid -> pump_v_o = 0, client_yumi_o = 0, grant held at 01.
REQ-035 RR off, clients 0 and 1 continuously valid -> client 1 never granted (starvation by design).
REQ-036 reset_n_i pulsed low at beat 4 of an 8-beat message -> busy_o and grant_o 0 immediately; after release, client 0 wins.
REQ-037 Pump stalls (pump_yumi_i = 0 for 5 cycles) in e_idle with clients 0 and 1 valid -> grant_o stable at the same client, no state change.
